// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response channel and data RAM ports of the memory-stage controller.
// The slave modport is the controller. The master modport is the pipeline and RAM side.
interface mem_access_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_data;
  logic        o_resp_err;
  logic        o_ram_we;
  logic [31:0] o_ram_w_addr;
  logic [31:0] o_ram_w_data;
  logic [31:0] o_ram_r_addr;
  logic [31:0] i_ram_r_data;
  logic [31:0] i_ram_r_addr;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_resp_ready, i_ram_r_data, i_ram_r_addr,
    output o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
    output o_ram_we, o_ram_w_addr, o_ram_w_data, o_ram_r_addr
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output i_resp_ready, i_ram_r_data, i_ram_r_addr,
    input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
    input  o_ram_we, o_ram_w_addr, o_ram_w_data, o_ram_r_addr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller for a word-wide RAM with a registered read port.
// Sub-word stores are done as read-modify-write. Each access returns exactly one response.
module mem_access_ctrl #(
  parameter bit CHECK_ECHO = 1'b1
) (
  input logic          i_Clk,
  input logic          i_reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      state, state_nxt;
  logic        op_we, op_we_nxt;
  logic [1:0]  op_size, op_size_nxt;
  logic        op_uns, op_uns_nxt;
  logic [31:0] op_addr, op_addr_nxt;
  logic [31:0] op_wdata, op_wdata_nxt;

  logic        ram_we, ram_we_nxt;
  logic [31:0] w_addr, w_addr_nxt;
  logic [31:0] w_data, w_data_nxt;
  logic [31:0] r_addr, r_addr_nxt;
  logic        resp_valid, resp_valid_nxt;
  logic [31:0] resp_data, resp_data_nxt;
  logic        resp_err, resp_err_nxt;

  // Decode of the incoming request, used only in the accept cycle
  logic [31:0] req_wa;
  logic        req_bad;
  assign req_wa  = {bus.i_req_addr[31:2], 2'b00};
  assign req_bad = (bus.i_req_size == SZ_ILL) ||
                   (bus.i_req_size == SZ_HALF && bus.i_req_addr[0]) ||
                   (bus.i_req_size == SZ_WORD && bus.i_req_addr[1:0] != 2'b00);

  // Lane extraction and merge against the captured read word
  logic [31:0] wa;
  logic [4:0]  byte_sh, half_sh;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext, merged;

  assign wa      = {op_addr[31:2], 2'b00};
  assign byte_sh = {op_addr[1:0], 3'b000};
  assign half_sh = {op_addr[1], 4'b0000};

  always_comb begin
    ld_b = bus.i_ram_r_data[7:0];
    case (op_addr[1:0])
      2'd0: ld_b = bus.i_ram_r_data[7:0];
      2'd1: ld_b = bus.i_ram_r_data[15:8];
      2'd2: ld_b = bus.i_ram_r_data[23:16];
      2'd3: ld_b = bus.i_ram_r_data[31:24];
      default: ld_b = bus.i_ram_r_data[7:0];
    endcase
    ld_h = op_addr[1] ? bus.i_ram_r_data[31:16] : bus.i_ram_r_data[15:0];
    case (op_size)
      SZ_BYTE: ld_ext = {{24{~op_uns & ld_b[7]}}, ld_b};
      SZ_HALF: ld_ext = {{16{~op_uns & ld_h[15]}}, ld_h};
      default: ld_ext = bus.i_ram_r_data;
    endcase
    if (op_size == SZ_BYTE)
      merged = (bus.i_ram_r_data & ~(32'h0000_00FF << byte_sh)) |
               ({24'h0, op_wdata[7:0]} << byte_sh);
    else
      merged = (bus.i_ram_r_data & ~(32'h0000_FFFF << half_sh)) |
               ({16'h0, op_wdata[15:0]} << half_sh);
  end

  always_comb begin
    state_nxt      = state;
    op_we_nxt      = op_we;
    op_size_nxt    = op_size;
    op_uns_nxt     = op_uns;
    op_addr_nxt    = op_addr;
    op_wdata_nxt   = op_wdata;
    ram_we_nxt     = 1'b0;
    w_addr_nxt     = w_addr;
    w_data_nxt     = w_data;
    r_addr_nxt     = r_addr;
    resp_valid_nxt = resp_valid;
    resp_data_nxt  = resp_data;
    resp_err_nxt   = resp_err;
    case (state)
      IDLE: begin
        if (bus.i_req_valid) begin
          op_we_nxt    = bus.i_req_we;
          op_size_nxt  = bus.i_req_size;
          op_uns_nxt   = bus.i_req_unsigned;
          op_addr_nxt  = bus.i_req_addr;
          op_wdata_nxt = bus.i_req_wdata;
          if (req_bad) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_data_nxt  = '0;
            resp_err_nxt   = 1'b1;
          end else if (!bus.i_req_we || bus.i_req_size != SZ_WORD) begin
            state_nxt  = RD_ISSUE;
            r_addr_nxt = req_wa;
          end else begin
            state_nxt  = WRITE;
            ram_we_nxt = 1'b1;
            w_addr_nxt = req_wa;
            w_data_nxt = bus.i_req_wdata;
          end
        end
      end
      RD_ISSUE: state_nxt = RD_CAPTURE;
      RD_CAPTURE: begin
        if (CHECK_ECHO && bus.i_ram_r_addr != wa) begin
          // A bad echo means the read word cannot be trusted, so no store merge either
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = '0;
          resp_err_nxt   = 1'b1;
        end else if (!op_we) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = ld_ext;
          resp_err_nxt   = 1'b0;
        end else begin
          state_nxt  = WRITE;
          ram_we_nxt = 1'b1;
          w_addr_nxt = wa;
          w_data_nxt = merged;
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = '0;
        resp_err_nxt   = 1'b0;
      end
      RESP: begin
        if (bus.i_resp_ready) begin
          state_nxt      = IDLE;
          resp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state      <= IDLE;
      op_we      <= 1'b0;
      op_size    <= '0;
      op_uns     <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      ram_we     <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      r_addr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_we      <= op_we_nxt;
      op_size    <= op_size_nxt;
      op_uns     <= op_uns_nxt;
      op_addr    <= op_addr_nxt;
      op_wdata   <= op_wdata_nxt;
      ram_we     <= ram_we_nxt;
      w_addr     <= w_addr_nxt;
      w_data     <= w_data_nxt;
      r_addr     <= r_addr_nxt;
      resp_valid <= resp_valid_nxt;
      resp_data  <= resp_data_nxt;
      resp_err   <= resp_err_nxt;
    end
  end

  assign bus.o_req_ready  = (state == IDLE);
  assign bus.o_ram_we     = ram_we;
  assign bus.o_ram_w_addr = w_addr;
  assign bus.o_ram_w_data = w_data;
  assign bus.o_ram_r_addr = r_addr;
  assign bus.o_resp_valid = resp_valid;
  assign bus.o_resp_data  = resp_data;
  assign bus.o_resp_err   = resp_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a small registered-read RAM model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl #(.CHECK_ECHO(1'b1)) dut (.i_Clk(clk), .i_reset(rst), .bus(bus));

  int pass_cnt = 0;
  int total    = 0;

  // RAM model: 64 words, one-cycle registered read, echo optionally corrupted
  logic [31:0] mem [64];
  logic        corrupt = 1'b0;
  logic        pre_we  = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.o_ram_we) mem[bus.o_ram_w_addr[7:2]] <= bus.o_ram_w_data;
    bus.i_ram_r_data <= mem[bus.o_ram_r_addr[7:2]];
    bus.i_ram_r_addr <= corrupt ? (bus.o_ram_r_addr ^ 32'h100) : bus.o_ram_r_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_we_cyc,
                        input int hold);
    int n, we_cnt, we_cyc;
    logic [31:0] d0;
    bus.i_resp_ready = (hold == 0);
    chk({tag, ".req_ready"}, 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_size = sz;
    bus.i_req_unsigned = uns; bus.i_req_addr = a; bus.i_req_wdata = wd;
    tick();
    bus.i_req_valid = 1'b0;
    n = 1; we_cnt = 0; we_cyc = -1;
    while (!bus.o_resp_valid && n < 12) begin
      if (bus.o_ram_we) begin we_cnt++; we_cyc = n; end
      tick();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".data"}, bus.o_resp_data, exp_data);
    chk({tag, ".err"}, 32'(bus.o_resp_err), 32'(exp_err));
    chk({tag, ".we_count"}, 32'(we_cnt), (exp_we_cyc < 0) ? 32'd0 : 32'd1);
    chk({tag, ".we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
    d0 = bus.o_resp_data;
    for (int h = 0; h < hold; h++) begin
      chk({tag, ".hold_valid"}, 32'(bus.o_resp_valid), 32'd1);
      chk({tag, ".hold_data"}, bus.o_resp_data, d0);
      chk({tag, ".hold_req_ready"}, 32'(bus.o_req_ready), 32'd0);
      tick();
    end
    bus.i_resp_ready = 1'b1;
    tick();
    chk({tag, ".resp_done"}, 32'(bus.o_resp_valid), 32'd0);
    chk({tag, ".req_ready_back"}, 32'(bus.o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] raddr_before;
    int we_seen, rv_seen;
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'b10;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = 32'h40; bus.i_req_wdata = 32'h5A5A5A5A;
    bus.i_resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.i_req_valid = 1'b0;
    chk("rst.req_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst.ram_we", 32'(bus.o_ram_we), 32'd0);
    chk("rst.resp_valid", 32'(bus.o_resp_valid), 32'd0);
    chk("rst.resp_err", 32'(bus.o_resp_err), 32'd0);
    chk("rst.resp_data", bus.o_resp_data, 32'h0);
    chk("rst.w_addr", bus.o_ram_w_addr, 32'h0);
    chk("rst.w_data", bus.o_ram_w_data, 32'h0);
    chk("rst.r_addr", bus.o_ram_r_addr, 32'h0);

    poke(6'd32, 32'h12F4A87C);
    poke(6'd8,  32'h11223344);

    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 0);
    chk("sw10.mem", mem[4], 32'hDEADBEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, -1, 0);

    do_req("lb81",  1'b0, 2'b00, 1'b0, 32'h81, 32'h0, 3, 32'hFFFFFFA8, 1'b0, -1, 0);
    do_req("lbu81", 1'b0, 2'b00, 1'b1, 32'h81, 32'h0, 3, 32'h000000A8, 1'b0, -1, 0);
    do_req("lbu83", 1'b0, 2'b00, 1'b1, 32'h83, 32'h0, 3, 32'h00000012, 1'b0, -1, 0);
    do_req("lh82",  1'b0, 2'b01, 1'b0, 32'h82, 32'h0, 3, 32'h000012F4, 1'b0, -1, 0);
    do_req("lh80",  1'b0, 2'b01, 1'b0, 32'h80, 32'h0, 3, 32'hFFFFA87C, 1'b0, -1, 0);
    do_req("lhu80", 1'b0, 2'b01, 1'b1, 32'h80, 32'h0, 3, 32'h0000A87C, 1'b0, -1, 0);

    do_req("sb22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AB, 4, 32'h0, 1'b0, 3, 0);
    chk("sb22.mem", mem[8], 32'h11AB3344);
    do_req("sh20", 1'b1, 2'b01, 1'b0, 32'h20, 32'h9876CAFE, 4, 32'h0, 1'b0, 3, 0);
    chk("sh20.mem", mem[8], 32'h11ABCAFE);

    do_req("lw80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 3, 32'h12F4A87C, 1'b0, -1, 0);
    raddr_before = bus.o_ram_r_addr;
    do_req("lw06",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 32'h0, 1'b1, -1, 0);
    do_req("sh03",  1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 1, 32'h0, 1'b1, -1, 0);
    do_req("sz11",  1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1, 32'h0, 1'b1, -1, 0);
    chk("err.r_addr_kept", bus.o_ram_r_addr, raddr_before);

    do_req("bp_lw80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 3, 32'h12F4A87C, 1'b0, -1, 5);

    corrupt = 1'b1;
    do_req("echo_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h0, 1'b1, -1, 0);
    corrupt = 1'b0;
    do_req("echo_sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h0, 4, 32'h0, 1'b0, 3, 0);
    chk("echo_sb21.mem", mem[8], 32'h11AB00FE);
    poke(6'd8, 32'h11ABCAFE);

    // Reset lands while the sub-word store is in its capture cycle
    chk("rmw_rst.req_ready", 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'b00;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = 32'h21; bus.i_req_wdata = 32'h55;
    tick();
    bus.i_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmw_rst.req_ready_after", 32'(bus.o_req_ready), 32'd1);
    chk("rmw_rst.ram_we", 32'(bus.o_ram_we), 32'd0);
    chk("rmw_rst.resp_valid", 32'(bus.o_resp_valid), 32'd0);
    chk("rmw_rst.resp_err", 32'(bus.o_resp_err), 32'd0);
    chk("rmw_rst.resp_data", bus.o_resp_data, 32'h0);
    chk("rmw_rst.w_addr", bus.o_ram_w_addr, 32'h0);
    chk("rmw_rst.w_data", bus.o_ram_w_data, 32'h0);
    chk("rmw_rst.r_addr", bus.o_ram_r_addr, 32'h0);
    we_seen = 0; rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_ram_we) we_seen++;
      if (bus.o_resp_valid) rv_seen++;
      tick();
    end
    chk("rmw_rst.no_write", 32'(we_seen), 32'd0);
    chk("rmw_rst.no_resp", 32'(rv_seen), 32'd0);
    chk("rmw_rst.mem", mem[8], 32'h11ABCAFE);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the RISC-V core. It is the initiator that drives the word-wide data RAM's write and read ports. It takes one load/store request at a time from the pipeline over a valid/ready handshake and covers the RAM's one-cycle registered read latency. Sub-word stores are done as read-modify-write because the RAM has only a whole-word write enable. Each access returns one response with load data or an error flag.

## Interface
- CHECK_ECHO, 1: when 1, a mismatch between the RAM's echoed read address and the issued word address flags a response error.
- i_Clk  in  1  sole clock. All state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset (`ResetEnable`), sampled on the i_Clk rising edge.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  high exactly when state = IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend sub-word loads.
- i_req_addr  in  32 (`RAMAddrBus`)  byte address.
- i_req_wdata  in  32 (`RAMDataBus`)  store data. Sub-word data is in the low bits.
- o_resp_valid  out  1  response held until accepted.
- i_resp_ready  in  1  pipeline accepts response.
- o_resp_data  out  32  extended load data. Zero for stores and errors.
- o_resp_err  out  1  misaligned, illegal size, or echo mismatch.
- o_ram_we  out  1  RAM write enable (`WriteEnable` = 1).
- o_ram_w_addr  out  32  RAM write address. Bits [1:0] are always 0.
- o_ram_w_data  out  32  RAM write word.
- o_ram_r_addr  out  32  RAM read address. Bits [1:0] are always 0.
- i_ram_r_data  in  32  RAM read word, valid one cycle after o_ram_r_addr is presented.
- i_ram_r_addr  in  32  RAM-echoed read address.

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WRITE, RESP.
- Accepting a request (i_req_valid & o_req_ready) latches op, size, unsigned, addr and wdata. Word address wa = addr & ~3. Lane = addr[1:0].
- Error check at accept:
  - size 11 is an error.
  - A half access with addr[0]=1 is an error.
  - A word access with addr[1:0]≠0 is an error.
  - On error: go to RESP with err=1 and data=0. The RAM is never driven.
- Load, or sub-word store: go to RD_ISSUE and set o_ram_r_addr=wa.
- Word store: go to WRITE and set o_ram_we=1, o_ram_w_addr=wa, o_ram_w_data=wdata.
- RD_ISSUE: hold o_ram_r_addr. The RAM registers the read at this cycle's end. Go to RD_CAPTURE.
- RD_CAPTURE: sample i_ram_r_data. If CHECK_ECHO=1 and i_ram_r_addr≠wa, go to RESP with err=1.
  - Load: extract the selected lane.
    - Byte: sign- or zero-extend data[8*lane+7 : 8*lane].
    - Half: sign- or zero-extend data[16*addr[1]+15 : 16*addr[1]].
    - Word: pass through.
    - Go to RESP with the extracted data.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane(s) of the read word. Other bytes are unchanged. Go to WRITE with o_ram_we=1, o_ram_w_addr=wa, and the merged word on o_ram_w_data.
- WRITE: o_ram_we is high for exactly this one cycle. Go to RESP with data=0, err=0.
- RESP: hold o_resp_valid, o_resp_data and o_resp_err until i_resp_ready=1. Then go to IDLE, deasserting o_resp_valid.
- o_ram_we is 0 in every state except WRITE.
- Read and write ports are never active in the same cycle.
- o_ram_r_addr keeps its last value outside RD_ISSUE. It has no side effects.

## Timing
- All outputs are registered, except o_req_ready, which is decoded from state.
- Reset (synchronous; effective on the edge where i_reset=1):
  - State goes to IDLE.
  - o_ram_we=0, o_resp_valid=0, o_resp_err=0.
  - o_resp_data, o_ram_w_addr, o_ram_w_data and o_ram_r_addr all go to 0.
  - o_req_ready=1 from the first cycle after reset.
  - Requests presented while i_reset=1 are ignored.
- Reset mid-operation aborts the access and produces no response.
  - If o_ram_we is already high in the reset cycle, that RAM write still lands, because the RAM samples the same edge.
  - Any later write is suppressed.
- Accept-to-o_resp_valid latency, with cycle 0 as the accept cycle:
  - Error: 1 cycle.
  - Word store: 2 cycles. o_ram_we is high in cycle 1.
  - Load: 3 cycles. RD_ISSUE in cycle 1, RD_CAPTURE in cycle 2.
  - Sub-word store: 4 cycles. o_ram_we is high in cycle 3.
- If i_resp_ready is already high when o_resp_valid rises, the response completes in that cycle. o_req_ready returns the next cycle.
- Peak throughput is one request per (latency+1) cycles. There is no overlap.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10. Required response: data 0xDEADBEEF, err=0. o_ram_we is high exactly once, in cycle 1 of the store.
- Signed and unsigned byte loads: RAM word 0x80 holds 0x12F4A87C.
  - lb at 0x81 returns 0xFFFFFFA8.
  - lbu at 0x81 returns 0x000000A8.
  - lh at 0x82 returns 0x000012F4.
- Sub-word store RMW: word 0x20 holds 0x11223344. sb of 0xAB to 0x22 writes 0x11AB3344 in cycle 3. sh of 0xCAFE to 0x20 then writes 0x11ABCAFE.
- Misalignment: lw at 0x06, sh at 0x03, and size 11 each respond err=1, data=0 at latency 1. o_ram_we stays 0 and o_ram_r_addr is not updated.
- Backpressure: hold i_resp_ready=0 for 5 cycles after a load. o_resp_valid and o_resp_data must stay stable and o_req_ready must stay 0. With CHECK_ECHO=1, force i_ram_r_addr≠wa; the response must have err=1.
- Reset mid-RMW: assert i_reset during RD_CAPTURE of an sb. The RAM must be unchanged and no response issued. o_req_ready=1 and all outputs are at their reset values on the next cycle.
